// File: rtl/ex_madd_seq.sv
// EX-stage multiply-accumulate sequencer for MADD/MADDU/MSUB/MSUBU.
// Product cycle stalls ID/EX; accumulate cycle drives the HI/LO write path.
module ex_madd_seq #(
    parameter logic [7:0] OP_MADD  = 8'b10100110,
    parameter logic [7:0] OP_MADDU = 8'b10101000,
    parameter logic [7:0] OP_MSUB  = 8'b10101010,
    parameter logic [7:0] OP_MSUBU = 8'b10101011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        hold_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [63:0] prod_r;
    logic [63:0] prod_nxt_s;
    logic        sub_r;
    logic        sub_nxt_s;
    logic        is_madd_s;
    logic        is_sub_s;
    logic        is_signed_s;
    logic [63:0] opa_s;
    logic [63:0] opb_s;
    logic [63:0] prod_s;
    logic [63:0] hilo_s;
    logic [63:0] acc_s;

    function automatic logic f_is_madd(input logic [7:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic f_is_sub(input logic [7:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic f_is_signed(input logic [7:0] op);
        return (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    assign is_madd_s   = f_is_madd(aluop_i);
    assign is_sub_s    = f_is_sub(aluop_i);
    assign is_signed_s = f_is_signed(aluop_i);

    // Extending both operands to 64 bits lets one 64-bit multiply serve signed and unsigned ops.
    assign opa_s  = is_signed_s ? {{32{reg1_i[31]}}, reg1_i} : {32'h0000_0000, reg1_i};
    assign opb_s  = is_signed_s ? {{32{reg2_i[31]}}, reg2_i} : {32'h0000_0000, reg2_i};
    assign prod_s = opa_s * opb_s;
    assign hilo_s = {hi_i, lo_i};
    assign hi_o   = acc_s[63:32];
    assign lo_o   = acc_s[31:0];

    // State, latched product and subtract flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            prod_r  <= 64'h0;
            sub_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            prod_r  <= prod_nxt_s;
            sub_r   <= sub_nxt_s;
        end
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        state_nxt_s = state_r;
        prod_nxt_s  = prod_r;
        sub_nxt_s   = sub_r;
        stallreq_o  = 1'b0;
        whilo_o     = 1'b0;
        busy_o      = 1'b0;
        acc_s       = 64'h0;
        case (state_r)
            ST_IDLE: begin
                if (is_madd_s) begin
                    stallreq_o = 1'b1;
                    if (!hold_i) begin
                        prod_nxt_s  = prod_s;
                        sub_nxt_s   = is_sub_s;
                        state_nxt_s = ST_ACC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                busy_o = 1'b1;
                if (is_madd_s) begin
                    whilo_o     = 1'b1;
                    acc_s       = sub_r ? (hilo_s - prod_r) : (hilo_s + prod_r);
                    state_nxt_s = hold_i ? ST_ACC : ST_IDLE;
                end else begin
                    // Flushed or bubbled instruction: drop the write and return to idle.
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_madd_seq.sv
// Self-checking bench for ex_madd_seq: behavioural model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_ex_madd_seq;

    localparam logic [7:0] OP_MADD  = 8'b10100110;
    localparam logic [7:0] OP_MADDU = 8'b10101000;
    localparam logic [7:0] OP_MSUB  = 8'b10101010;
    localparam logic [7:0] OP_MSUBU = 8'b10101011;
    localparam logic [7:0] OP_NOP   = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2, hi_in, lo_in;
    logic        hold;
    logic        stallreq, whilo, busy;
    logic [31:0] hi_out, lo_out;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    typedef struct {
        logic [63:0] prod;
        bit          sub;
    } pend_t;
    pend_t pend_q[$];

    ex_madd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .aluop_i   (aluop),
        .reg1_i    (reg1),
        .reg2_i    (reg2),
        .hi_i      (hi_in),
        .lo_i      (lo_in),
        .hold_i    (hold),
        .stallreq_o(stallreq),
        .whilo_o   (whilo),
        .hi_o      (hi_out),
        .lo_o      (lo_out),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_madd(input logic [7:0] op);
        return op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
    endfunction

    function automatic logic [63:0] m_product(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        if (op == OP_MADD || op == OP_MSUB) return 64'(sa * sb);
        else return 64'(ua * ub);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending-product queue; a non-empty queue means an accumulate is due.
    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            if (!m_is_madd(aluop) || !hold) pend_q.delete();
        end else if (m_is_madd(aluop) && !hold) begin
            pend_t p;
            p.prod = m_product(aluop, reg1, reg2);
            p.sub  = (aluop == OP_MSUB || aluop == OP_MSUBU);
            pend_q.push_back(p);
        end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            logic        e_stall, e_whilo, e_busy;
            logic [63:0] e_res;
            e_stall = 1'b0; e_whilo = 1'b0; e_busy = 1'b0; e_res = 64'h0;
            if (pend_q.size() == 0) begin
                e_stall = m_is_madd(aluop);
            end else begin
                e_busy = 1'b1;
                if (m_is_madd(aluop)) begin
                    e_whilo = 1'b1;
                    e_res = pend_q[0].sub ? ({hi_in, lo_in} - pend_q[0].prod)
                                          : ({hi_in, lo_in} + pend_q[0].prod);
                end
            end
            chk("model_stallreq", 64'(stallreq), 64'(e_stall));
            chk("model_whilo", 64'(whilo), 64'(e_whilo));
            chk("model_busy", 64'(busy), 64'(e_busy));
            chk("model_hilo", {hi_out, lo_out}, e_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input logic hd);
        aluop = op; reg1 = a; reg2 = b; hi_in = h; lo_in = l; hold = hd;
    endtask

    // Full two-cycle op with literal expectations on both cycles.
    task automatic do_op(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(op, a, b, h, l, 1'b0);
        @(negedge clk);
        chk({name, "_c0_stall"}, 64'(stallreq), 64'd1);
        chk({name, "_c0_whilo"}, 64'(whilo), 64'd0);
        tick();
        @(negedge clk);
        chk({name, "_c1_stall"}, 64'(stallreq), 64'd0);
        chk({name, "_c1_whilo"}, 64'(whilo), 64'd1);
        chk({name, "_c1_hilo"}, {hi_out, lo_out}, {exp_hi, exp_lo});
        tick();
    endtask

    task automatic idle();
        drive(OP_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("idle_outputs", {31'h0, stallreq, whilo, busy, hi_out, lo_out}, 64'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(OP_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {31'h0, stallreq, whilo, busy, hi_out, lo_out}, 64'h0);
        tick();
        rst = 1'b0;
        idle();

        do_op("madd_basic", OP_MADD, 32'd3, 32'd4, 32'h0, 32'd5, 32'h0, 32'h11);
        idle();
        do_op("maddu_ff", OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h1);
        do_op("madd_ff", OP_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h1);
        do_op("msub_neg", OP_MSUB, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 32'h0, 32'h2);
        do_op("madd_wrap", OP_MADD, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
        do_op("msubu_wrap", OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();

        // Back-to-back: stall 1,0,1,0 and whilo 0,1,0,1 are checked inside do_op.
        do_op("b2b_a", OP_MADD, 32'd2, 32'd3, 32'h0, 32'h0, 32'h0, 32'h6);
        do_op("b2b_b", OP_MADD, 32'd5, 32'd7, 32'h0, 32'h1, 32'h0, 32'h24);
        idle();

        // Hold for three cycles in the accumulate cycle.
        drive(OP_MADDU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h2, 1'b0);
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_acc_busy", 64'(busy), 64'd1);
            chk("hold_acc_whilo", 64'(whilo), 64'd1);
            chk("hold_acc_hilo", {hi_out, lo_out}, 64'h0000_0002_0000_0002);
            tick();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("hold_release_hilo", {hi_out, lo_out}, 64'h0000_0002_0000_0002);
        tick();
        idle();

        // Hold while idle: stall request persists, no advance.
        drive(OP_MADD, 32'd6, 32'd7, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_idle_stall", 64'(stallreq), 64'd1);
            chk("hold_idle_busy", 64'(busy), 64'd0);
            tick();
        end
        hold = 1'b0;
        tick();
        @(negedge clk);
        chk("hold_idle_result", {hi_out, lo_out}, 64'd42);
        tick();
        idle();

        // Abort: bubble during the accumulate cycle, with hold asserted.
        drive(OP_MADD, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0);
        tick();
        drive(OP_NOP, 32'd9, 32'd9, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("abort_whilo", 64'(whilo), 64'd0);
        chk("abort_hilo", {hi_out, lo_out}, 64'h0);
        tick();
        hold = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 64'(busy), 64'd0);
        tick();

        // Reset during the accumulate cycle, coinciding with hold.
        drive(OP_MADD, 32'd8, 32'd8, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        hold = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        do_op("after_reset", OP_MADD, 32'd8, 32'd8, 32'h0, 32'h1, 32'h0, 32'h41);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
